uart_tx_fifo: RTL and testbench

Byte buffer and launch sequencer directly upstream of uart_tx. Accepts bytes from a producer through a write strobe and stores them in a circular FIFO. Hands each byte to uart_tx through the data/start/busy handshake, one byte at a time, back-to-back while data remains. Runs on the single 50 MHz system clock.

---
 rtl/uart_pkg.sv | 11 +
 rtl/sync_fifo.sv | 51 +++++
 rtl/uart_tx_fifo.sv | 94 +++++++++
 tb/tb_uart_tx_fifo.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared byte width, clock rate and launch-FSM state encoding for the uart_tx front end
package uart_pkg;
    localparam int BYTE_W = 8;
    localparam int CLK_HZ = 50_000_000;
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: circular byte FIFO with occupancy count and a sticky overflow flag
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              wr_en_i,
    input  logic [BYTE_W-1:0] wr_data_i,
    input  logic              pop_i,
    input  logic              ovf_clr_i,
    output logic [BYTE_W-1:0] rd_data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   count_o,
    output logic              overflow_o
);
    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic              overflow_q;
    logic              push, pop;

    assign full_o     = count_q == (ADDR_W+1)'(DEPTH);
    assign empty_o    = count_q == '0;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign rd_data_o  = mem_q[rd_ptr_q];
    assign push       = wr_en_i && !full_o;
    assign pop        = pop_i && !empty_o;

    always_ff @(posedge clk_i)
        if (push) mem_q[wr_ptr_q] <= wr_data_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= push ? wr_ptr_q + 1'b1 : wr_ptr_q;
            rd_ptr_q   <= pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
            count_q    <= count_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
            // clear wins over a write attempted while full in the same cycle
            overflow_q <= ovf_clr_i ? 1'b0 : (wr_en_i && full_o) ? 1'b1 : overflow_q;
        end
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffers producer bytes and launches them one at a time into uart_tx via start/busy
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int START_CYCLES = 1,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              wr_en_i,
    input  logic [BYTE_W-1:0] wr_data_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   count_o,
    output logic              overflow_o,
    input  logic              ovf_clr_i,
    output logic [BYTE_W-1:0] tx_data_o,
    output logic              tx_start_o,
    input  logic              tx_busy_i,
    output logic              tx_timeout_o
);
    localparam int TW = 8;

    tx_state_e         state_q;
    logic [TW-1:0]     timer_q;
    logic [BYTE_W-1:0] tx_data_q, rd_data;
    logic              tx_start_q, tx_timeout_q, pop;

    // IDLE looks at the registered count, so a byte written this edge is not popped until the next
    assign pop          = state_q == IDLE && !empty_o && !tx_busy_i;
    assign tx_data_o    = tx_data_q;
    assign tx_start_o   = tx_start_q;
    assign tx_timeout_o = tx_timeout_q;

    sync_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .wr_en_i    (wr_en_i),
        .wr_data_i  (wr_data_i),
        .pop_i      (pop),
        .ovf_clr_i  (ovf_clr_i),
        .rd_data_o  (rd_data),
        .full_o     (full_o),
        .empty_o    (empty_o),
        .count_o    (count_o),
        .overflow_o (overflow_o)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            tx_timeout_q <= 1'b0;
        end else begin
            if (ovf_clr_i) tx_timeout_q <= 1'b0;
            case (state_q)
                IDLE:
                    if (pop) begin
                        state_q    <= LAUNCH;
                        tx_start_q <= 1'b1;
                        tx_data_q  <= rd_data;
                        timer_q    <= TW'(1);
                    end
                LAUNCH:
                    if (timer_q == TW'(START_CYCLES)) begin
                        state_q    <= WAIT_BUSY;
                        tx_start_q <= 1'b0;
                        timer_q    <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                WAIT_BUSY:
                    if (tx_busy_i) begin
                        state_q <= WAIT_DONE;
                        timer_q <= '0;
                    end else if (timer_q == TW'(BUSY_TIMEOUT - 1)) begin
                        // byte is abandoned; uart_tx never acknowledged it
                        state_q <= IDLE;
                        timer_q <= '0;
                        if (!ovf_clr_i) tx_timeout_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                WAIT_DONE:
                    if (!tx_busy_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of buffering, launch timing, overflow, timeout and reset abort
module tb_uart_tx_fifo;
    logic       clk = 1'b0, rst = 1'b1;
    logic       wr_en = 1'b0, ovf_clr = 1'b0, tx_busy = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty, overflow, tx_start, tx_timeout;
    logic [4:0] count;
    logic [7:0] tx_data;

    int passed = 0, total = 0, peak = 0;
    bit model_en = 1'b0, force_busy = 1'b0;
    int sd = 0, bl = 0;
    logic [7:0] launches [$];

    uart_tx_fifo dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .wr_en_i      (wr_en),
        .wr_data_i    (wr_data),
        .full_o       (full),
        .empty_o      (empty),
        .count_o      (count),
        .overflow_o   (overflow),
        .ovf_clr_i    (ovf_clr),
        .tx_data_o    (tx_data),
        .tx_start_o   (tx_start),
        .tx_busy_i    (tx_busy),
        .tx_timeout_o (tx_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en = 1'b1;
        wr_data = b;
        tick();
        wr_en = 1'b0;
    endtask

    // uart_tx stand-in: busy rises 2 cycles after start, stays high 10 cycles
    initial forever begin
        @(negedge clk);
        if (rst) begin
            tx_busy = 1'b0;
            sd = 0;
            bl = 0;
        end else begin
            chk("start_vs_busy", {31'b0, tx_start & tx_busy}, 32'd0);
            if (tx_start) launches.push_back(tx_data);
            if (int'(count) > peak) peak = int'(count);
            if (force_busy) tx_busy = 1'b1;
            else if (bl > 0) begin
                bl--;
                tx_busy = bl != 0;
            end else if (sd > 0) begin
                sd--;
                if (sd == 0) begin
                    tx_busy = 1'b1;
                    bl = 10;
                end
            end else begin
                tx_busy = 1'b0;
                if (model_en && tx_start) sd = 2;
            end
        end
    end

    initial begin
        tick(3);
        rst = 1'b0;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_tmo", tx_timeout, 0);
        chk("rst_start", tx_start, 0);
        chk("rst_data", tx_data, 0);
        model_en = 1'b1;

        write_byte(8'hAA);
        chk("t1_count", count, 1);
        chk("t1_start_c1", tx_start, 0);
        tick();
        chk("t1_start_c2", tx_start, 1);
        chk("t1_data", tx_data, 8'hAA);
        chk("t1_empty", empty, 1);
        tick();
        chk("t1_start_c3", tx_start, 0);
        tick(20);
        chk("t1_tmo", tx_timeout, 0);
        chk("t1_nlaunch", launches.size(), 1);
        chk("t1_byte", launches[0], 8'hAA);
        launches.delete();

        peak = 0;
        for (int i = 1; i <= 5; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(i);
            tick();
        end
        wr_en = 1'b0;
        tick(100);
        chk("t2_nlaunch", launches.size(), 5);
        for (int i = 0; i < 5; i++) chk($sformatf("t2_byte%0d", i), launches[i], i + 1);
        chk("t2_peak", peak, 4);
        chk("t2_count", count, 0);
        launches.delete();

        force_busy = 1'b1;
        tick(2);
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'h10 + i);
            tick();
        end
        wr_en = 1'b0;
        chk("t3_count", count, 16);
        chk("t3_full", full, 1);
        chk("t3_ovf", overflow, 1);
        chk("t3_nolaunch", launches.size(), 0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t3_ovf_clr", overflow, 0);
        force_busy = 1'b0;
        tick(260);
        chk("t3_nlaunch", launches.size(), 16);
        for (int i = 0; i < 16; i++) chk($sformatf("t3_byte%0d", i), launches[i], 8'h10 + i);
        chk("t3_empty", empty, 1);
        launches.delete();

        for (int i = 0; i < 19; i++) begin
            write_byte(8'(8'h40 + i));
            tick(7);
        end
        tick(200);
        chk("t4_nlaunch", launches.size(), 19);
        for (int i = 0; i < 19; i++) chk($sformatf("t4_byte%0d", i), launches[i], 8'h40 + i);
        chk("t4_ovf", overflow, 0);
        chk("t4_count", count, 0);
        launches.delete();

        model_en = 1'b0;
        write_byte(8'h77);
        tick();
        chk("t5_start", tx_start, 1);
        tick();
        chk("t5_start_fall", tx_start, 0);
        tick(15);
        chk("t5_tmo_early", tx_timeout, 0);
        tick();
        chk("t5_tmo", tx_timeout, 1);
        chk("t5_state", dut.state_q, 0);
        model_en = 1'b1;
        write_byte(8'h88);
        tick();
        chk("t5_next_start", tx_start, 1);
        chk("t5_next_data", tx_data, 8'h88);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t5_tmo_clr", tx_timeout, 0);
        tick(30);
        launches.delete();

        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'h31 + i);
            tick();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 50 && dut.state_q != 2'd3; i++) tick();
        chk("t6_wait_done", dut.state_q, 3);
        chk("t6_queued", count, 3);
        #2 rst = 1'b1;
        #1;
        chk("t6_count", count, 0);
        chk("t6_start", tx_start, 0);
        chk("t6_data", tx_data, 0);
        chk("t6_state", dut.state_q, 0);
        chk("t6_empty", empty, 1);
        tick(2);
        rst = 1'b0;
        launches.delete();
        tick(40);
        chk("t6_nolaunch", launches.size(), 0);
        write_byte(8'h99);
        tick();
        chk("t6_new_start", tx_start, 1);
        chk("t6_new_data", tx_data, 8'h99);
        tick(20);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
